// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, funct codes,
// ALU encodings and the 4-bit controller state encoding.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle. Pure level signals, no handshake: the
// controller reads op/funct/zero and drives all selects/enables every cycle.
interface mips_multicycle_ctrl_if;
  import mips_multicycle_ctrl_pkg::*;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       irwrite;
  logic       regwrite;
  logic       memwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  state_t     state;

  modport master (
    input  op, funct, zero,
    output pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, state
  );

  modport slave (
    output op, funct, zero,
    input  pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ALU decoder: aluop from the main FSM plus funct -> 3-bit ALU control.
module mips_multicycle_ctrl_aludec
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unknown funct falls to AND; the FSM still performs the writeback.
        case (i_funct)
          FN_ADD:  o_alucontrol = ALU_ADD;
          FN_SUB:  o_alucontrol = ALU_SUB;
          FN_AND:  o_alucontrol = ALU_AND;
          FN_OR:   o_alucontrol = ALU_OR;
          FN_SLT:  o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_AND;
        endcase
      end
      default: o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl_maindec.sv
// Main control FSM: sequences fetch/decode/execute/memory/writeback and emits
// Moore controls. Write enables are held low combinationally while reset is high.
module mips_multicycle_ctrl_maindec
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  output state_t     o_state,
  output logic       o_pcwrite,
  output logic       o_branch,
  output logic       o_irwrite,
  output logic       o_regwrite,
  output logic       o_memwrite,
  output logic       o_iord,
  output logic       o_memtoreg,
  output logic       o_regdst,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_pcsrc,
  output logic [1:0] o_aluop
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_FETCH;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    o_pcwrite  = 1'b0;
    o_branch   = 1'b0;
    o_irwrite  = 1'b0;
    o_regwrite = 1'b0;
    o_memwrite = 1'b0;
    o_iord     = 1'b0;
    o_memtoreg = 1'b0;
    o_regdst   = 1'b0;
    o_alusrca  = 1'b0;
    o_alusrcb  = 2'b00;
    o_pcsrc    = 2'b00;
    o_aluop    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        o_alusrcb = 2'b01;
        o_irwrite = 1'b1;
        o_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        o_alusrcb = 2'b11;
        case (i_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        w_next    = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        o_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_memtoreg = 1'b1;
        o_regwrite = 1'b1;
      end
      S_MEMWR: begin
        o_iord     = 1'b1;
        o_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        o_alusrca = 1'b1;
        o_aluop   = ALUOP_FUNCT;
        w_next    = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        o_regdst   = 1'b1;
        o_regwrite = 1'b1;
      end
      S_BEQEX: begin
        o_alusrca = 1'b1;
        o_aluop   = ALUOP_SUB;
        o_pcsrc   = 2'b01;
        o_branch  = 1'b1;
      end
      S_ADDIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: o_regwrite = 1'b1;
      S_JEX: begin
        o_pcsrc   = 2'b10;
        o_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    // Async reset puts state at FETCH at once; suppress its side effects.
    if (i_reset) begin
      o_pcwrite  = 1'b0;
      o_branch   = 1'b0;
      o_irwrite  = 1'b0;
      o_regwrite = 1'b0;
      o_memwrite = 1'b0;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller top: main FSM + ALU decoder; forms the PC enable.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  logic       w_pcwrite;
  logic       w_branch;
  logic [1:0] w_aluop;

  mips_multicycle_ctrl_maindec u_maindec (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_op       (bus.op),
    .o_state    (bus.state),
    .o_pcwrite  (w_pcwrite),
    .o_branch   (w_branch),
    .o_irwrite  (bus.irwrite),
    .o_regwrite (bus.regwrite),
    .o_memwrite (bus.memwrite),
    .o_iord     (bus.iord),
    .o_memtoreg (bus.memtoreg),
    .o_regdst   (bus.regdst),
    .o_alusrca  (bus.alusrca),
    .o_alusrcb  (bus.alusrcb),
    .o_pcsrc    (bus.pcsrc),
    .o_aluop    (w_aluop)
  );

  mips_multicycle_ctrl_aludec u_aludec (
    .i_aluop      (w_aluop),
    .i_funct      (bus.funct),
    .o_alucontrol (bus.alucontrol)
  );

  assign bus.pcen = w_pcwrite | (w_branch & bus.zero);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class through
// its state sequence and compares every control output against hand-built vectors.
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {state[3:0], pcen, irwrite, regwrite, memwrite, iord,
  //                 memtoreg, regdst, alusrca, alusrcb[1:0], pcsrc[1:0], alucontrol[2:0]}
  localparam logic [18:0] V_RST     = {4'd0,  8'b0000_0000, 2'b01, 2'b00, 3'b010};
  localparam logic [18:0] V_FETCH   = {4'd0,  8'b1100_0000, 2'b01, 2'b00, 3'b010};
  localparam logic [18:0] V_DECODE  = {4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010};
  localparam logic [18:0] V_MEMADR  = {4'd2,  8'b0000_0001, 2'b10, 2'b00, 3'b010};
  localparam logic [18:0] V_MEMRD   = {4'd3,  8'b0000_1000, 2'b00, 2'b00, 3'b010};
  localparam logic [18:0] V_MEMWB   = {4'd4,  8'b0010_0100, 2'b00, 2'b00, 3'b010};
  localparam logic [18:0] V_MEMWR   = {4'd5,  8'b0001_1000, 2'b00, 2'b00, 3'b010};
  localparam logic [18:0] V_RTEX_SLT= {4'd6,  8'b0000_0001, 2'b00, 2'b00, 3'b111};
  localparam logic [18:0] V_RTEX_SUB= {4'd6,  8'b0000_0001, 2'b00, 2'b00, 3'b110};
  localparam logic [18:0] V_RTEX_UNK= {4'd6,  8'b0000_0001, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] V_RTWB    = {4'd7,  8'b0010_0010, 2'b00, 2'b00, 3'b010};
  localparam logic [18:0] V_BEQ_T   = {4'd8,  8'b1000_0001, 2'b00, 2'b01, 3'b110};
  localparam logic [18:0] V_BEQ_NT  = {4'd8,  8'b0000_0001, 2'b00, 2'b01, 3'b110};
  localparam logic [18:0] V_ADDIEX  = {4'd9,  8'b0000_0001, 2'b10, 2'b00, 3'b010};
  localparam logic [18:0] V_ADDIWB  = {4'd10, 8'b0010_0000, 2'b00, 2'b00, 3'b010};
  localparam logic [18:0] V_JEX     = {4'd11, 8'b1000_0000, 2'b00, 2'b10, 3'b010};

  function automatic logic [18:0] observed();
    return {bus.state, bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite,
            bus.iord, bus.memtoreg, bus.regdst, bus.alusrca,
            bus.alusrcb, bus.pcsrc, bus.alucontrol};
  endfunction

  task automatic chk(input string tag, input logic [18:0] exp);
    logic [18:0] obs;
    obs = observed();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    bus.op    = op;
    bus.funct = funct;
    bus.zero  = zero;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    set_instr(OP_LW, 6'd0, 1'b0);

    // Reset held for three edges: FETCH selects, all enables low
    #1;
    chk("rst_0", V_RST);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_%0d", i + 1), V_RST);
    end
    reset = 1'b0;
    #1;
    chk("rel_fetch", V_FETCH);

    // lw: 5 cycles
    set_instr(OP_LW, 6'd0, 1'b0);
    step(); chk("lw_decode", V_DECODE);
    step(); chk("lw_memadr", V_MEMADR);
    step(); chk("lw_memrd",  V_MEMRD);
    step(); chk("lw_memwb",  V_MEMWB);
    step(); chk("lw_fetch",  V_FETCH);

    // sw: 4 cycles, memwrite in cycle 4 only
    set_instr(OP_SW, 6'd0, 1'b0);
    step(); chk("sw_decode", V_DECODE);
    step(); chk("sw_memadr", V_MEMADR);
    step(); chk("sw_memwr",  V_MEMWR);
    step(); chk("sw_fetch",  V_FETCH);

    // R-type slt
    set_instr(OP_RTYPE, FN_SLT, 1'b0);
    step(); chk("slt_decode", V_DECODE);
    step(); chk("slt_ex",     V_RTEX_SLT);
    step(); chk("slt_wb",     V_RTWB);
    step(); chk("slt_fetch",  V_FETCH);

    // R-type sub
    set_instr(OP_RTYPE, FN_SUB, 1'b0);
    step(); chk("sub_decode", V_DECODE);
    step(); chk("sub_ex",     V_RTEX_SUB);
    step(); chk("sub_wb",     V_RTWB);
    step(); chk("sub_fetch",  V_FETCH);

    // R-type unsupported funct: ALU gets AND, writeback still happens
    set_instr(OP_RTYPE, 6'b111111, 1'b0);
    step(); chk("unk_decode", V_DECODE);
    step(); chk("unk_ex",     V_RTEX_UNK);
    step(); chk("unk_wb",     V_RTWB);
    step(); chk("unk_fetch",  V_FETCH);

    // beq taken
    set_instr(OP_BEQ, 6'd0, 1'b1);
    step(); chk("beqt_decode", V_DECODE);
    step(); chk("beqt_ex",     V_BEQ_T);
    step(); chk("beqt_fetch",  V_FETCH);

    // beq not taken
    set_instr(OP_BEQ, 6'd0, 1'b0);
    step(); chk("beqn_decode", V_DECODE);
    step(); chk("beqn_ex",     V_BEQ_NT);
    step(); chk("beqn_fetch",  V_FETCH);

    // addi
    set_instr(OP_ADDI, 6'd0, 1'b0);
    step(); chk("addi_decode", V_DECODE);
    step(); chk("addi_ex",     V_ADDIEX);
    step(); chk("addi_wb",     V_ADDIWB);
    step(); chk("addi_fetch",  V_FETCH);

    // j, with zero high to show it does not matter outside BEQEX
    set_instr(OP_J, 6'd0, 1'b1);
    step(); chk("j_decode", V_DECODE);
    step(); chk("j_ex",     V_JEX);
    step(); chk("j_fetch",  V_FETCH);

    // Unknown opcode: DECODE straight back to FETCH
    set_instr(6'b111111, 6'd0, 1'b0);
    step(); chk("nop_decode", V_DECODE);
    step(); chk("nop_fetch",  V_FETCH);

    // Reset pulsed during MEMADR of a sw
    set_instr(OP_SW, 6'd0, 1'b0);
    step(); chk("swr_decode", V_DECODE);
    step(); chk("swr_memadr", V_MEMADR);
    reset = 1'b1;
    #1;
    chk("swr_rst_now", V_RST);
    step(); chk("swr_rst_edge", V_RST);
    reset = 1'b0;
    #1;
    chk("swr_rel_fetch", V_FETCH);
    step(); chk("swr_decode2", V_DECODE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stalled clock
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
